cam_stream_gen: RTL and testbench

Synthesizable, parametrised OV7670-style camera stream generator. Drives vsync/href/byte-data frames with configurable geometry, bytes per pixel and test-pattern mode. Replaces hand-written bench stimulus for capture logic (flappy_bird_logic camera path) and doubles as an on-chip camera substitute for board bring-up. One byte per clock cycle.

---
 rtl/cam_gen_pkg.sv | 32 +++
 rtl/cam_pattern_src.sv | 72 +++++++
 rtl/cam_stream_gen.sv | 129 ++++++++++++
 tb/tb_cam_stream_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cam_gen_pkg.sv
// Shared constants for the camera stream generator: FSM states, pattern modes,
// colour-bar palette and LFSR feedback.
package cam_gen_pkg;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_VSYNC  = 3'd1;
    localparam state_t ST_VBACK  = 3'd2;
    localparam state_t ST_ACTIVE = 3'd3;
    localparam state_t ST_VFRONT = 3'd4;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black)
    localparam logic [7:0][15:0] BAR_RGB565 = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/cam_pattern_src.sv
// Test-pattern byte source: latches mode/constant per frame, runs the LFSR and
// picks the byte for the requested pixel and byte index.
module cam_pattern_src
    import cam_gen_pkg::*;
#(
    parameter int          H_ACTIVE  = 640,
    parameter int          BPP       = 2,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          X_W       = 10,
    parameter int          BI_W      = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              reseed,
    input  logic              advance,
    input  logic [1:0]        mode,
    input  logic [15:0]       const_px,
    input  logic [X_W-1:0]    x,
    input  logic [BI_W-1:0]   byte_idx,
    output logic [DATA_W-1:0] byte_out
);

    localparam int PW = DATA_W * BPP;

    mode_e             mode_reg;
    logic [15:0]       const_reg;
    logic [15:0]       lfsr_reg;
    logic [2:0]        bar_idx;
    logic [PW-1:0]     pixel;
    logic [BI_W-1:0]   byte_sel;
    logic [DATA_W-1:0] px_bytes [BPP];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_reg  <= MODE_LFSR;
            const_reg <= '0;
            lfsr_reg  <= LFSR_SEED;
        end else if (reseed) begin
            mode_reg  <= mode_e'(mode);
            const_reg <= const_px;
            lfsr_reg  <= LFSR_SEED;
        end else if (advance) begin
            lfsr_reg  <= lfsr_step(lfsr_reg);
        end
    end

    assign bar_idx = 3'((int'(x) * 8) / H_ACTIVE);

    always_comb begin
        pixel = '0;
        case (mode_reg)
            MODE_RAMP:  pixel = PW'(x);
            MODE_BARS:  pixel = (BPP == 1) ? PW'(BAR_RGB565[bar_idx][15:8])
                                           : PW'(BAR_RGB565[bar_idx]);
            MODE_CONST: pixel = PW'(const_reg);
            default:    pixel = '0;
        endcase
    end

    // Byte 0 of a pixel on the wire is its most significant byte
    generate
        for (genvar gi = 0; gi < BPP; gi++) begin : g_bytes
            assign px_bytes[gi] = pixel[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign byte_sel = BI_W'(BPP - 1) - byte_idx;
    assign byte_out = (mode_reg == MODE_LFSR) ? lfsr_reg[DATA_W-1:0]
                                              : px_bytes[byte_sel];

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style frame generator: line/frame counters, sync FSM and registered
// vsync/href/data outputs, one byte per clock.
module cam_stream_gen
    import cam_gen_pkg::*;
#(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_BLANK   = 144,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_SYNC    = 3,
    parameter int          V_BACK    = 17,
    parameter int          V_FRONT   = 10,
    parameter int          BPP       = 2,
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic [15:0]       const_px,
    output logic              cam_vsync,
    output logic              cam_href,
    output logic [DATA_W-1:0] cam_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam int LINE_LEN  = (H_ACTIVE + H_BLANK) * BPP;
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int ACT_BYTES = H_ACTIVE * BPP;
    localparam int HC_W      = $clog2(LINE_LEN);
    localparam int VC_W      = $clog2(V_TOTAL);
    localparam int X_W       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int BI_W      = (BPP > 1) ? $clog2(BPP) : 1;

    state_t            state_reg, state_next;
    logic [HC_W-1:0]   hcnt_reg, hcnt_next;
    logic [VC_W-1:0]   vcnt_reg, vcnt_next;
    logic              href_next, reseed, last_next;
    logic [DATA_W-1:0] pat_byte;

    function automatic state_t line_state(input logic [VC_W-1:0] v);
        if (int'(v) < V_SYNC)                       return ST_VSYNC;
        else if (int'(v) < V_SYNC + V_BACK)         return ST_VBACK;
        else if (int'(v) < V_SYNC + V_BACK + V_ACTIVE) return ST_ACTIVE;
        else                                        return ST_VFRONT;
    endfunction

    // Outputs are registered from the next position, so the pulse for a
    // position appears in the same cycle the counters reach it.
    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        vcnt_next  = vcnt_reg;
        if (state_reg == ST_IDLE) begin
            if (run) begin
                state_next = ST_VSYNC;
                hcnt_next  = '0;
                vcnt_next  = '0;
            end
        end else if (hcnt_reg == HC_W'(LINE_LEN - 1)) begin
            hcnt_next = '0;
            if (vcnt_reg == VC_W'(V_TOTAL - 1)) begin
                vcnt_next  = '0;
                state_next = run ? ST_VSYNC : ST_IDLE;
            end else begin
                vcnt_next  = vcnt_reg + 1'b1;
                state_next = line_state(vcnt_reg + 1'b1);
            end
        end else begin
            hcnt_next = hcnt_reg + 1'b1;
        end
    end

    assign href_next = (state_next == ST_ACTIVE) && (int'(hcnt_next) < ACT_BYTES);
    assign reseed    = (state_next == ST_VSYNC) && (state_reg != ST_VSYNC);
    assign last_next = (state_next != ST_IDLE) && (hcnt_next == HC_W'(LINE_LEN - 1))
                       && (vcnt_next == VC_W'(V_TOTAL - 1));

    cam_pattern_src #(
        .H_ACTIVE (H_ACTIVE),
        .BPP      (BPP),
        .DATA_W   (DATA_W),
        .LFSR_SEED(LFSR_SEED),
        .X_W      (X_W),
        .BI_W     (BI_W)
    ) u_pattern (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .reseed   (reseed),
        .advance  (href_next),
        .mode     (mode),
        .const_px (const_px),
        .x        (X_W'(hcnt_next / BPP)),
        .byte_idx (BI_W'(hcnt_next % BPP)),
        .byte_out (pat_byte)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg   <= ST_IDLE;
            hcnt_reg    <= '0;
            vcnt_reg    <= '0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            busy        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hcnt_reg    <= hcnt_next;
            vcnt_reg    <= vcnt_next;
            cam_vsync   <= (state_next == ST_VSYNC);
            cam_href    <= href_next;
            cam_data    <= href_next ? pat_byte : '0;
            frame_start <= reseed;
            frame_done  <= last_next;
            if (last_next) begin
                frame_count <= frame_count + 16'd1;
            end
            busy        <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen on a 20-cycle x 7-line geometry.
module tb_cam_stream_gen;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        run;
    logic [1:0]  mode;
    logic [15:0] const_px;
    logic        cam_vsync, cam_href, frame_start, frame_done, busy;
    logic [7:0]  cam_data;
    logic [15:0] frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    int n_vs, n_hr, n_rise, fd_at, fs_at, dat_bad;
    logic [7:0] bytes_q[$];
    logic [7:0] first_q[$];
    logic [7:0] exp_bar [16];

    cam_stream_gen #(
        .H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(4), .V_SYNC(1), .V_BACK(1),
        .V_FRONT(1), .BPP(2), .DATA_W(8), .LFSR_SEED(16'hACE1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .run        (run),
        .mode       (mode),
        .const_px   (const_px),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one frame; k=1 is the first negedge after the call.
    task automatic capture(input int bound, input int chg_at, input int drop_at);
        logic prev_hr;
        prev_hr = 1'b0;
        n_vs = 0; n_hr = 0; n_rise = 0; fd_at = -1; fs_at = -1; dat_bad = 0;
        bytes_q.delete();
        for (int k = 1; k <= bound; k++) begin
            @(negedge sys_clk);
            if (cam_vsync) n_vs++;
            if (frame_start && fs_at < 0) fs_at = k;
            if (cam_href) begin
                n_hr++;
                bytes_q.push_back(cam_data);
                if (!prev_hr) n_rise++;
            end else if (cam_data != 8'h00) begin
                dat_bad++;
            end
            prev_hr = cam_href;
            if (k == chg_at) begin mode = 2'd1; const_px = 16'h0000; end
            if (k == drop_at) run = 1'b0;
            if (frame_done) begin fd_at = k; break; end
        end
    endtask

    initial begin
        int bad;
        exp_bar = '{8'hFF,8'hFF,8'hFF,8'hE0,8'h07,8'hFF,8'h07,8'hE0,
                    8'hF8,8'h1F,8'hF8,8'h00,8'h00,8'h1F,8'h00,8'h00};
        sys_rst_n = 1'b0; run = 1'b0; mode = 2'd1; const_px = 16'h0000;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        bad = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (cam_vsync || cam_href || cam_data != 0 || frame_start || frame_done || busy || frame_count != 0) bad++;
        end
        check("idle_nonzero_cycles", bad, 0);
        check("idle_busy", busy, 0);
        check("idle_frame_count", frame_count, 0);

        // Frame 1: ramp
        run = 1'b1;
        capture(200, 0, 0);
        check("ramp_frame_start_at", fs_at, 1);
        check("ramp_frame_done_at", fd_at, 140);
        check("ramp_vsync_cycles", n_vs, 20);
        check("ramp_href_pulses", n_rise, 4);
        check("ramp_href_cycles", n_hr, 64);
        check("ramp_data_outside_href", dat_bad, 0);
        check("ramp_frame_count", frame_count, 1);
        for (int i = 0; i < 16; i++)
            check($sformatf("ramp_line0_byte%0d", i), bytes_q[i], (i % 2 == 0) ? 0 : i / 2);

        // Frame 2: colour bars, back-to-back
        mode = 2'd2;
        capture(200, 0, 0);
        check("bars_back_to_back_start", fs_at, 1);
        check("bars_frame_done_at", fd_at, 140);
        check("bars_frame_count", frame_count, 2);
        for (int i = 0; i < 16; i++)
            check($sformatf("bars_byte%0d", i), bytes_q[i], exp_bar[i]);

        // Frames 3,4: LFSR, must repeat exactly
        mode = 2'd0;
        capture(200, 0, 0);
        check("lfsr_byte0", bytes_q[0], 8'hE1);
        check("lfsr_byte1", bytes_q[1], 8'h70);
        check("lfsr_byte2", bytes_q[2], 8'h38);
        check("lfsr_byte3", bytes_q[3], 8'h9C);
        first_q = bytes_q;
        capture(200, 0, 0);
        check("lfsr_repeat_len", bytes_q.size(), 64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (bytes_q[i] !== first_q[i]) bad++;
        check("lfsr_repeat_mismatches", bad, 0);
        check("lfsr_frame_count", frame_count, 4);

        // Frame 5: constant, mode changed mid-frame
        mode = 2'd3; const_px = 16'h1234;
        capture(200, 30, 0);
        bad = 0;
        for (int i = 0; i < bytes_q.size(); i++)
            if (bytes_q[i] !== ((i % 2 == 0) ? 8'h12 : 8'h34)) bad++;
        check("const_bytes_wrong", bad, 0);
        check("const_href_cycles", n_hr, 64);

        // Frame 6: ramp from the shadowed change, run dropped mid-frame
        capture(200, 0, 50);
        check("ramp2_byte3", bytes_q[3], 8'h01);
        check("ramp2_byte15", bytes_q[15], 8'h07);
        check("drop_frame_done_at", fd_at, 140);
        check("drop_frame_count", frame_count, 6);
        repeat (3) @(negedge sys_clk);
        check("drop_idle_busy", busy, 0);
        check("drop_idle_vsync", cam_vsync, 0);

        // Asynchronous reset in the middle of an active line
        run = 1'b1;
        bad = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (cam_href) begin bad = 0; break; end
        end
        check("href_seen_before_reset", bad, 0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_href", cam_href, 0);
        check("rst_data", cam_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        @(negedge sys_clk);
        run = 1'b0;
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("post_rst_idle_busy", busy, 0);
        check("post_rst_idle_vsync", cam_vsync, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
